bpi_cmd_sequencer: RTL and testbench

Command-level controller sitting above the BPI flash bus interface. It accepts one flash operation at a time (read word, program word, erase block, unlock block, read status, clear status, read array) and expands it into the required sequence of single bus cycles (write/read, EXECUTE, wait for BUSY). For program and erase it polls the flash status register until ready, then reports status and error. The block is placed between the VME/JTAG command decoders and the BPI bus interface; it is the only block that drives that interface's request inputs.

---
 rtl/bpi_pkg.sv | 50 +++++
 rtl/bpi_seq_steps.sv | 63 ++++++
 rtl/bpi_cmd_sequencer.sv | 162 ++++++++++++++++
 tb/tb_bpi_cmd_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bpi_pkg.sv
// Shared definitions for the BPI command sequencer: command codes, flash
// command words, status register bit positions, bus op encodings and FSM states.
package bpi_pkg;

  typedef enum logic [2:0] {
    CMD_READ       = 3'd0,
    CMD_PROGRAM    = 3'd1,
    CMD_ERASE      = 3'd2,
    CMD_UNLOCK     = 3'd3,
    CMD_RD_STATUS  = 3'd4,
    CMD_CLR_STATUS = 3'd5,
    CMD_RD_ARRAY   = 3'd6,
    CMD_ILLEGAL    = 3'd7
  } cmd_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_NEXT,
    S_FINISH
  } state_e;

  localparam logic [15:0] FL_READ_ARRAY = 16'h00FF;
  localparam logic [15:0] FL_PROGRAM    = 16'h0040;
  localparam logic [15:0] FL_ERASE      = 16'h0020;
  localparam logic [15:0] FL_CONFIRM    = 16'h00D0;
  localparam logic [15:0] FL_UNLOCK     = 16'h0060;
  localparam logic [15:0] FL_RD_STATUS  = 16'h0070;
  localparam logic [15:0] FL_CLR_STATUS = 16'h0050;

  localparam int SR_READY     = 7;
  localparam int SR_ERASE_ERR = 5;
  localparam int SR_PROG_ERR  = 4;
  localparam int SR_LOCK_ERR  = 1;

  localparam logic [1:0] OP_IDLE  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  // Program/erase step layout: two setup writes, poll write/read pair, exit write
  localparam logic [2:0] STEP_POLL_W = 3'd2;
  localparam logic [2:0] STEP_POLL_R = 3'd3;
  localparam logic [2:0] STEP_EXIT   = 3'd4;

  function automatic logic sr_error(input logic [7:0] sr);
    return sr[SR_ERASE_ERR] | sr[SR_PROG_ERR] | sr[SR_LOCK_ERR];
  endfunction

endpackage

// File: rtl/bpi_seq_steps.sv
// Combinational step table: maps (command, step index) to the bus cycle to
// issue and flags marking the last step, the poll read and data-returning reads.
module bpi_seq_steps
  import bpi_pkg::*;
(
  input  cmd_e        cmd,
  input  logic [2:0]  step,
  input  logic [15:0] wdata,
  output logic [1:0]  op,
  output logic [15:0] data,
  output logic        last,
  output logic        poll,
  output logic        rd
);

  always_comb begin
    op   = OP_WRITE;
    data = FL_READ_ARRAY;
    last = 1'b0;
    poll = 1'b0;
    rd   = 1'b0;
    case (cmd)
      CMD_READ, CMD_RD_STATUS: begin
        if (step == 3'd0) begin
          data = (cmd == CMD_READ) ? FL_READ_ARRAY : FL_RD_STATUS;
        end else begin
          op   = OP_READ;
          data = '0;
          last = 1'b1;
          rd   = 1'b1;
        end
      end
      CMD_PROGRAM, CMD_ERASE: begin
        case (step)
          3'd0:        data = (cmd == CMD_PROGRAM) ? FL_PROGRAM : FL_ERASE;
          3'd1:        data = (cmd == CMD_PROGRAM) ? wdata : FL_CONFIRM;
          STEP_POLL_W: data = FL_RD_STATUS;
          STEP_POLL_R: begin
            op   = OP_READ;
            data = '0;
            poll = 1'b1;
          end
          default:     last = 1'b1;
        endcase
      end
      CMD_UNLOCK: begin
        data = (step == 3'd0) ? FL_UNLOCK : FL_CONFIRM;
        last = (step != 3'd0);
      end
      CMD_CLR_STATUS: begin
        data = FL_CLR_STATUS;
        last = 1'b1;
      end
      CMD_RD_ARRAY: last = 1'b1;
      default: begin
        op   = OP_IDLE;
        data = '0;
        last = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/bpi_cmd_sequencer.sv
// Expands flash commands into BPI bus cycles and polls status for program/erase.
// Optional bounded polling is enabled by defining BPI_SEQ_TIMEOUT_EN.
module bpi_cmd_sequencer
  import bpi_pkg::*;
#(
  parameter logic [23:0] POLL_MAX = 24'd4_000_000
) (
  input  logic        CLK,
  input  logic        RST_B,
  input  logic [2:0]  CMD,
  input  logic [22:0] CMD_ADDR,
  input  logic [15:0] CMD_WDATA,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  output logic [15:0] RD_DATA,
  output logic        RD_VALID,
  output logic        DONE,
  output logic        ERROR,
  output logic [7:0]  STATUS,
  output logic [22:0] BPI_ADDR,
  output logic [15:0] BPI_DATA,
  output logic [1:0]  BPI_OP,
  output logic        BPI_EXECUTE,
  input  logic        BPI_BUSY,
  input  logic        BPI_LOAD,
  input  logic [15:0] BPI_DIN
);

  state_e      state, state_nxt;
  cmd_e        cmd_q;
  logic [22:0] addr_q;
  logic [15:0] wdata_q;
  logic [2:0]  step_q;
  logic        guard_q;
  logic        got_load_q;
  logic [15:0] rdata_q;
  logic        rd_valid_q;

  logic [1:0]  dec_op;
  logic [15:0] dec_data;
  logic        dec_last, dec_poll, dec_rd;
  logic        accept, wait_done, bus_active, poll_expired;
  logic [15:0] din_final;

  bpi_seq_steps u_steps (
    .cmd   (cmd_q),
    .step  (step_q),
    .wdata (wdata_q),
    .op    (dec_op),
    .data  (dec_data),
    .last  (dec_last),
    .poll  (dec_poll),
    .rd    (dec_rd)
  );

  assign accept     = CMD_VALID && (state == S_IDLE);
  assign wait_done  = (state == S_WAIT) && guard_q && !BPI_BUSY;
  assign bus_active = (state == S_ISSUE) || (state == S_WAIT);
  // A LOAD strobe earlier in the cycle wins; otherwise take the bus data at BUSY fall
  assign din_final  = (got_load_q && !BPI_LOAD) ? rdata_q : BPI_DIN;

`ifdef BPI_SEQ_TIMEOUT_EN
  logic [23:0] poll_cnt_q;

  always_ff @(posedge CLK) begin
    if (!RST_B || accept) begin
      poll_cnt_q <= '0;
    end else if ((state == S_NEXT) && dec_poll && !rdata_q[SR_READY]) begin
      poll_cnt_q <= poll_cnt_q + 24'd1;
    end
  end

  assign poll_expired = (poll_cnt_q + 24'd1) >= POLL_MAX;
`else
  logic unused_poll_max;
  assign unused_poll_max = ^POLL_MAX;
  assign poll_expired    = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!RST_B) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (CMD_VALID) state_nxt = (CMD == CMD_ILLEGAL) ? S_FINISH : S_ISSUE;
      S_ISSUE:  if (!BPI_BUSY) state_nxt = S_WAIT;
      S_WAIT:   if (guard_q && !BPI_BUSY) state_nxt = S_NEXT;
      S_NEXT:   state_nxt = dec_last ? S_FINISH : S_ISSUE;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign CMD_READY   = (state == S_IDLE);
  assign DONE        = (state == S_FINISH);
  assign RD_VALID    = rd_valid_q;
  assign BPI_EXECUTE = (state == S_ISSUE) && !BPI_BUSY;
  assign BPI_OP      = bus_active ? dec_op : OP_IDLE;
  assign BPI_DATA    = bus_active ? dec_data : '0;
  assign BPI_ADDR    = addr_q;

  always_ff @(posedge CLK) begin
    if (!RST_B) begin
      cmd_q      <= CMD_READ;
      addr_q     <= '0;
      wdata_q    <= '0;
      step_q     <= '0;
      guard_q    <= 1'b0;
      got_load_q <= 1'b0;
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
      RD_DATA    <= '0;
      ERROR      <= 1'b0;
      STATUS     <= '0;
    end else begin
      rd_valid_q <= 1'b0;
      guard_q    <= (state == S_WAIT);
      if (accept) begin
        cmd_q      <= cmd_e'(CMD);
        addr_q     <= CMD_ADDR;
        wdata_q    <= CMD_WDATA;
        step_q     <= '0;
        got_load_q <= 1'b0;
        ERROR      <= (CMD == CMD_ILLEGAL);
      end
      if (state == S_WAIT) begin
        if (BPI_LOAD) begin
          rdata_q    <= BPI_DIN;
          got_load_q <= 1'b1;
        end
        if (wait_done) begin
          rdata_q    <= din_final;
          got_load_q <= 1'b0;
          if (dec_rd) begin
            RD_DATA    <= din_final;
            rd_valid_q <= 1'b1;
          end
          if (dec_poll || (dec_rd && (cmd_q == CMD_RD_STATUS))) STATUS <= din_final[7:0];
        end
      end
      if (state == S_NEXT) begin
        if (dec_poll) begin
          if (rdata_q[SR_READY]) begin
            ERROR  <= ERROR | sr_error(rdata_q[7:0]);
            step_q <= STEP_EXIT;
          end else if (poll_expired) begin
            ERROR  <= 1'b1;
            step_q <= STEP_EXIT;
          end else begin
            step_q <= STEP_POLL_W;
          end
        end else if (!dec_last) begin
          step_q <= step_q + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bpi_cmd_sequencer.sv
// Bench for bpi_cmd_sequencer: table vectors, hand corner cases and random
// commands against a command-level flash/bus model.
module tb_bpi_cmd_sequencer;

  logic        CLK = 1'b0;
  logic        RST_B = 1'b0;
  logic [2:0]  CMD = 3'd0;
  logic [22:0] CMD_ADDR = '0;
  logic [15:0] CMD_WDATA = '0;
  logic        CMD_VALID = 1'b0;
  logic        CMD_READY;
  logic [15:0] RD_DATA;
  logic        RD_VALID;
  logic        DONE;
  logic        ERROR;
  logic [7:0]  STATUS;
  logic [22:0] BPI_ADDR;
  logic [15:0] BPI_DATA;
  logic [1:0]  BPI_OP;
  logic        BPI_EXECUTE;
  logic        BPI_BUSY = 1'b0;
  logic        BPI_LOAD = 1'b0;
  logic [15:0] BPI_DIN = '0;

  bpi_cmd_sequencer #(.POLL_MAX(24'd5)) dut (
    .CLK(CLK), .RST_B(RST_B), .CMD(CMD), .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .RD_DATA(RD_DATA), .RD_VALID(RD_VALID),
    .DONE(DONE), .ERROR(ERROR), .STATUS(STATUS), .BPI_ADDR(BPI_ADDR), .BPI_DATA(BPI_DATA),
    .BPI_OP(BPI_OP), .BPI_EXECUTE(BPI_EXECUTE), .BPI_BUSY(BPI_BUSY), .BPI_LOAD(BPI_LOAD),
    .BPI_DIN(BPI_DIN)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  op;
    logic [22:0] addr;
    logic [15:0] data;
  } txn_t;

  txn_t        txq[$];
  txn_t        expq[$];
  logic [7:0]  stat_seq[$];
  logic [7:0]  stuck = 8'h80;
  logic [15:0] array_word = '0;
  logic [15:0] mode = 16'h00FF;
  bit          no_load = 1'b0;
  int          busy_cnt = 0;

  int checks = 0;
  int failures = 0;

  // Flash model: answers status while in read-status mode, array data otherwise
  function automatic logic [15:0] flash_read();
    if (mode == 16'h0070) begin
      if (stat_seq.size() > 0) return {8'h00, stat_seq.pop_front()};
      return {8'h00, stuck};
    end
    return array_word;
  endfunction

  always @(posedge CLK) begin
    BPI_LOAD <= 1'b0;
    if (!RST_B) begin
      BPI_BUSY <= 1'b0;
      busy_cnt <= 0;
    end else if (BPI_EXECUTE) begin
      txq.push_back('{BPI_OP, BPI_ADDR, (BPI_OP == 2'b01) ? BPI_DATA : 16'h0000});
      busy_cnt <= $urandom_range(4, 1);
      BPI_BUSY <= 1'b1;
      if (BPI_OP == 2'b01) begin
        mode <= BPI_DATA;
      end else if (BPI_OP == 2'b10) begin
        BPI_DIN  <= flash_read();
        BPI_LOAD <= !no_load;
      end
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) BPI_BUSY <= 1'b0;
      if (!no_load) BPI_DIN <= 16'hDEAD;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic void pw(input logic [22:0] a, input logic [15:0] d);
    expq.push_back('{2'b01, a, d});
  endfunction

  function automatic void pr(input logic [22:0] a);
    expq.push_back('{2'b10, a, 16'h0000});
  endfunction

  // Expected bus cycles of one command, straight from the command step lists
  function automatic void build_exp(input logic [2:0] c, input logic [22:0] a,
                                    input logic [15:0] w, input int polls);
    expq.delete();
    case (c)
      3'd0: begin pw(a, 16'h00FF); pr(a); end
      3'd1, 3'd2: begin
        pw(a, (c == 3'd1) ? 16'h0040 : 16'h0020);
        pw(a, (c == 3'd1) ? w : 16'h00D0);
        for (int k = 0; k < polls; k++) begin pw(a, 16'h0070); pr(a); end
        pw(a, 16'h00FF);
      end
      3'd3: begin pw(a, 16'h0060); pw(a, 16'h00D0); end
      3'd4: begin pw(a, 16'h0070); pr(a); end
      3'd5: pw(a, 16'h0050);
      3'd6: pw(a, 16'h00FF);
      default: ;
    endcase
  endfunction

  task automatic compare_txns(input string tag);
    int n;
    chk($sformatf("%s.ntx", tag), txq.size(), expq.size());
    n = (txq.size() < expq.size()) ? txq.size() : expq.size();
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s.tx%0d.op", tag, k), txq[k].op, expq[k].op);
      chk($sformatf("%s.tx%0d.addr", tag, k), txq[k].addr, expq[k].addr);
      chk($sformatf("%s.tx%0d.data", tag, k), txq[k].data, expq[k].data);
    end
  endtask

  task automatic prepare(input int npoll, input logic [7:0] fstat, input logic [15:0] arr, input bit nl);
    stat_seq.delete();
    for (int k = 0; k < npoll; k++) stat_seq.push_back(8'($urandom_range(127, 0)));
    stat_seq.push_back(fstat);
    stuck      = fstat;
    array_word = arr;
    no_load    = nl;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".ready"}, CMD_READY, 1);
    chk({tag, ".rd_data"}, RD_DATA, 0);
    chk({tag, ".rd_valid"}, RD_VALID, 0);
    chk({tag, ".done"}, DONE, 0);
    chk({tag, ".error"}, ERROR, 0);
    chk({tag, ".status"}, STATUS, 0);
    chk({tag, ".bpi_addr"}, BPI_ADDR, 0);
    chk({tag, ".bpi_data"}, BPI_DATA, 0);
    chk({tag, ".bpi_op"}, BPI_OP, 0);
    chk({tag, ".bpi_exec"}, BPI_EXECUTE, 0);
  endtask

  int          rdv_cnt, done_cnt;
  logic [15:0] rdv_data;
  logic        exec1, done_first, err_s;
  logic [7:0]  st_s;

  task automatic run_cmd(input logic [2:0] c, input logic [22:0] a, input logic [15:0] w, input bit hold);
    int n;
    txq.delete();
    rdv_cnt = 0; done_cnt = 0; rdv_data = '0; err_s = 1'b0; st_s = '0;
    n = 0;
    while (!CMD_READY && n < 200) begin @(negedge CLK); n++; end
    chk("ready_before_cmd", CMD_READY, 1);
    CMD = c; CMD_ADDR = a; CMD_WDATA = w; CMD_VALID = 1'b1;
    @(negedge CLK);
    if (hold) CMD = 3'd2;
    else      CMD_VALID = 1'b0;
    exec1 = BPI_EXECUTE;
    done_first = DONE;
    for (int i = 0; i < 3000; i++) begin
      if (RD_VALID) begin rdv_cnt++; rdv_data = RD_DATA; end
      if (DONE) begin done_cnt++; err_s = ERROR; st_s = STATUS; break; end
      @(negedge CLK);
    end
    CMD_VALID = 1'b0;
    @(negedge CLK);
    if (DONE) done_cnt++;
  endtask

  typedef struct {
    logic [2:0]  cmd;
    logic [22:0] addr;
    logic [15:0] wdata;
    logic [15:0] arr;
    int          npoll;
    logic [7:0]  fstat;
    bit          nl;
    int          ntx;
    int          nrdv;
    logic [15:0] rd;
    bit          err;
    logic [7:0]  st;
  } vec_t;

  vec_t vt[9];

  initial begin
    logic [2:0]  c;
    logic [22:0] a;
    logic [15:0] w, arr;
    logic [7:0]  fs, exp_status;
    int          np, ex_cnt, dn_cnt;
    bit          nl, pl, exp_err;

    vt[0] = '{3'd0, 23'h000123, 16'h0000, 16'hBEEF, 0, 8'h80, 1'b0, 2, 1, 16'hBEEF, 1'b0, 8'h00};
    vt[1] = '{3'd1, 23'h001000, 16'hA5A5, 16'h0000, 3, 8'h80, 1'b0, 11, 0, 16'h0000, 1'b0, 8'h80};
    vt[2] = '{3'd2, 23'h020000, 16'h0000, 16'h0000, 1, 8'hA0, 1'b1, 7, 0, 16'h0000, 1'b1, 8'hA0};
    vt[3] = '{3'd3, 23'h040000, 16'h0000, 16'h0000, 0, 8'h80, 1'b0, 2, 0, 16'h0000, 1'b0, 8'hA0};
    vt[4] = '{3'd4, 23'h000000, 16'h0000, 16'h0000, 0, 8'h92, 1'b0, 2, 1, 16'h0092, 1'b0, 8'h92};
    vt[5] = '{3'd5, 23'h000010, 16'h0000, 16'h0000, 0, 8'h80, 1'b0, 1, 0, 16'h0000, 1'b0, 8'h92};
    vt[6] = '{3'd6, 23'h7FFFFF, 16'h0000, 16'h0000, 0, 8'h80, 1'b0, 1, 0, 16'h0000, 1'b0, 8'h92};
    vt[7] = '{3'd0, 23'h3ABCDE, 16'h0000, 16'h1234, 0, 8'h80, 1'b1, 2, 1, 16'h1234, 1'b0, 8'h92};
    vt[8] = '{3'd1, 23'h000055, 16'h0070, 16'h0000, 0, 8'h90, 1'b0, 5, 0, 16'h0000, 1'b1, 8'h90};

    repeat (3) @(negedge CLK);
    check_reset("reset");
    RST_B = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < 9; i++) begin
      prepare(vt[i].npoll, vt[i].fstat, vt[i].arr, vt[i].nl);
      run_cmd(vt[i].cmd, vt[i].addr, vt[i].wdata, 1'b0);
      build_exp(vt[i].cmd, vt[i].addr, vt[i].wdata,
                (vt[i].cmd == 3'd1 || vt[i].cmd == 3'd2) ? vt[i].npoll + 1 : 0);
      compare_txns($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.ntx_table", i), txq.size(), vt[i].ntx);
      chk($sformatf("vec%0d.first_exec", i), exec1, 1);
      chk($sformatf("vec%0d.done", i), done_cnt, 1);
      chk($sformatf("vec%0d.rd_valid", i), rdv_cnt, vt[i].nrdv);
      if (vt[i].nrdv != 0) chk($sformatf("vec%0d.rd_data", i), rdv_data, vt[i].rd);
      chk($sformatf("vec%0d.error", i), err_s, vt[i].err);
      chk($sformatf("vec%0d.status", i), st_s, vt[i].st);
    end

    // Illegal command: no bus cycles, immediate DONE, sticky ERROR
    run_cmd(3'd7, 23'h000001, 16'h0000, 1'b0);
    chk("illegal.ntx", txq.size(), 0);
    chk("illegal.done_next_cycle", done_first, 1);
    chk("illegal.done", done_cnt, 1);
    chk("illegal.error", err_s, 1);
    chk("illegal.status", st_s, 8'h90);
    chk("illegal.error_sticky", ERROR, 1);

    // CMD_VALID held high (with another command) throughout a PROGRAM
    prepare(1, 8'h80, 16'h0000, 1'b0);
    run_cmd(3'd1, 23'h000777, 16'h5A5A, 1'b1);
    build_exp(3'd1, 23'h000777, 16'h5A5A, 2);
    compare_txns("hold");
    chk("hold.done", done_cnt, 1);
    chk("hold.error", err_s, 0);
    repeat (3) @(negedge CLK);
    chk("hold.no_requeue", txq.size(), expq.size());
    chk("hold.ready", CMD_READY, 1);

`ifdef BPI_SEQ_TIMEOUT_EN
    prepare(0, 8'h00, 16'h0000, 1'b0);
    stat_seq.delete();
    run_cmd(3'd2, 23'h010000, 16'h0000, 1'b0);
    build_exp(3'd2, 23'h010000, 16'h0000, 5);
    compare_txns("timeout");
    chk("timeout.done", done_cnt, 1);
    chk("timeout.error", err_s, 1);
    chk("timeout.status", st_s, 8'h00);
`endif

    // Reset while an ERASE bus cycle is in its BUSY wait
    prepare(0, 8'h00, 16'h0000, 1'b0);
    stat_seq.delete();
    txq.delete();
    CMD = 3'd2; CMD_ADDR = 23'h030000; CMD_VALID = 1'b1;
    @(negedge CLK);
    CMD_VALID = 1'b0;
    np = 0;
    while (!(BPI_BUSY && BPI_OP != 2'b00) && np < 100) begin @(negedge CLK); np++; end
    chk("rstmid.reached_wait", BPI_BUSY, 1);
    RST_B = 1'b0;
    @(negedge CLK);
    check_reset("rstmid");
    RST_B = 1'b1;
    ex_cnt = 0; dn_cnt = 0;
    repeat (10) begin
      @(negedge CLK);
      if (BPI_EXECUTE) ex_cnt++;
      if (DONE) dn_cnt++;
    end
    chk("rstmid.no_exec", ex_cnt, 0);
    chk("rstmid.no_done", dn_cnt, 0);

    exp_status = 8'h00;
    for (int i = 0; i < 40; i++) begin
      c   = ($urandom_range(9, 0) == 0) ? 3'd7 : 3'($urandom_range(6, 0));
      a   = 23'($urandom);
      w   = 16'($urandom);
      arr = 16'($urandom);
      nl  = 1'($urandom);
      pl  = (c == 3'd1) || (c == 3'd2);
      np  = pl ? $urandom_range(3, 0) : 0;
      fs  = pl ? (8'h80 | 8'($urandom)) : 8'($urandom);
      prepare(np, fs, arr, nl);
      run_cmd(c, a, w, 1'b0);
      build_exp(c, a, w, pl ? np + 1 : 0);
      compare_txns($sformatf("rnd%0d", i));
      if (pl || c == 3'd4) exp_status = fs;
      exp_err = (c == 3'd7) ? 1'b1 : (pl ? ((fs & 8'h32) != 8'h00) : 1'b0);
      chk($sformatf("rnd%0d.done", i), done_cnt, 1);
      chk($sformatf("rnd%0d.error", i), err_s, exp_err);
      chk($sformatf("rnd%0d.status", i), st_s, exp_status);
      chk($sformatf("rnd%0d.rd_valid", i), rdv_cnt, (c == 3'd0 || c == 3'd4) ? 1 : 0);
      if (c == 3'd0) chk($sformatf("rnd%0d.rd_data", i), rdv_data, arr);
      if (c == 3'd4) chk($sformatf("rnd%0d.rd_data", i), rdv_data, {8'h00, fs});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
